data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: DATA_SIZE, default 8, data width.
REQ-002 Parameter: ARG_SIZE, default 8, address width.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0  input  1  core (port 0) access request; held until granted.
REQ-006 wr0  input  1  port 0 access type: 1 = write, 0 = read.
REQ-007 lock0  input  1  port 0 keeps ownership after this grant.
REQ-008 addr0  input  ARG_SIZE  port 0 address.
REQ-009 wrData0  input  DATA_SIZE  port 0 write value.
REQ-010 req1, wr1, lock1, addr1, wrData1  input  1/1/1/ARG_SIZE/DATA_SIZE  host (port 1) equivalents.
REQ-011 gnt0, gnt1  output  1 each  combinational grant, this cycle's request accepted.
REQ-012 rdValid0, rdValid1  output  1 each  rdData holds read result for that port.
REQ-013 rdData  output  DATA_SIZE  shared read-return data.
REQ-014 memRdEn, memWrEn  output  1 each  registered memory commands.
REQ-015 memAddr  output  ARG_SIZE  registered memory address.
REQ-016 memWrData  output  DATA_SIZE  registered memory write value.
REQ-017 memRdData  input  DATA_SIZE  memory read data, valid one cycle after memRdEn.

Function
REQ-018 States: ARB (no owner), OWN0, OWN1.
REQ-019 In ARB, a single request is granted.
REQ-020 In ARB, simultaneous requests grant the port not granted last (lastGnt register).
REQ-021 In OWNn, only port n can be granted; the other port's gnt is 0 regardless of its req.
REQ-022 Transition: a grant with lockn=1 goes to OWNn; a grant with lockn=0, or OWNn with reqn=0, goes to ARB.
REQ-023 At most one gnt is high per cycle; a gnt is never high without its req.
REQ-024 The cycle after a grant: memAddr/memWrData take the granted port's values; memWrEn=wrn; memRdEn=~wrn.
REQ-025 With no grant: memRdEn=memWrEn=0 next cycle; memAddr and memWrData are don't-care.
REQ-026 Read latency: granted read at cycle N -> memRdEn at N+1 -> rdData=memRdData with rdValidn=1 at N+2.
REQ-027 rdValidn is a one-cycle pulse per granted read; a write produces no rdValid.
REQ-028 Throughput: one grant per cycle sustained; reads and writes may be back-to-back and interleaved.
REQ-029 A read-tag pipeline (2 stages: valid + port id) tracks outstanding reads.
REQ-030 lastGnt updates on every grant, including grants in OWNn.

Reset
REQ-031 Asserting reset immediately forces: state=ARB; lastGnt=1 (port 0 wins the first tie); memRdEn=memWrEn=0; rdValid0=rdValid1=0; tag pipeline cleared.
REQ-032 Reset asserted mid-operation discards in-flight reads; no rdValid is produced for them after release.
REQ-033 Under reset: rdData=0, memAddr=0, memWrData=0.
REQ-034 gnt0=gnt1=0 while reset is low.

Structure
REQ-035 DATA_SIZE, ARG_SIZE and the arbiter state encodings live in the shared CPU constants package alongside the opcode constants.
REQ-036 Single module; the grant picker is inline combinational logic, with no sub-module.

Verification
REQ-037 Reset state: release reset with req0=req1=1, wr=0 -> gnt0=1 first cycle, gnt1=1 next cycle (alternation).
REQ-038 Port 1 read latency: port 1 writes 8'hA5 to addr 8'h10, then reads addr 8'h10 -> rdValid1 pulses 2 cycles after the read grant with rdData=8'hA5; rdValid0 stays 0.
REQ-039 Lock: port 0 lock0=1 for 3 grants while req1=1 -> gnt1=0 throughout; gnt1=1 on the cycle after lock0 drops and the grant completes.
REQ-040 Back-to-back interleaving: alternating reads from both ports every cycle -> every cycle has a memRdEn, and each rdValid is routed to the correct port in order.
REQ-041 Reset mid-read: assert reset the cycle after a read grant -> no rdValid pulse after release; the first tie after release grants port 0.
REQ-042 No request: req0=req1=0 for 5 cycles -> gnt, mem enables and rdValid all stay 0.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared CPU constants: data/address widths, opcode encodings and the
// data-memory arbiter state encoding.
package data_mem_arbiter_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_ARG_SIZE  = 8;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports, read return and memory command bus
// seen by the data-memory arbiter.
interface data_mem_arbiter_if
    import data_mem_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ARG_SIZE  = DEF_ARG_SIZE
);
    logic                 req0, wr0, lock0;
    logic [ARG_SIZE-1:0]  addr0;
    logic [DATA_SIZE-1:0] wrData0;
    logic                 req1, wr1, lock1;
    logic [ARG_SIZE-1:0]  addr1;
    logic [DATA_SIZE-1:0] wrData1;
    logic                 gnt0, gnt1;
    logic                 rdValid0, rdValid1;
    logic [DATA_SIZE-1:0] rdData;
    logic                 memRdEn, memWrEn;
    logic [ARG_SIZE-1:0]  memAddr;
    logic [DATA_SIZE-1:0] memWrData;
    logic [DATA_SIZE-1:0] memRdData;

    modport slave (
        input  req0, wr0, lock0, addr0, wrData0,
        input  req1, wr1, lock1, addr1, wrData1,
        input  memRdData,
        output gnt0, gnt1, rdValid0, rdValid1, rdData,
        output memRdEn, memWrEn, memAddr, memWrData
    );

    modport master (
        output req0, wr0, lock0, addr0, wrData0,
        output req1, wr1, lock1, addr1, wrData1,
        output memRdData,
        input  gnt0, gnt1, rdValid0, rdValid1, rdData,
        input  memRdEn, memWrEn, memAddr, memWrData
    );

endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port data-memory arbiter: core (port 0) and host (port 1) share one
// memory; lock-based ownership, alternating tie-break, tagged read return.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ARG_SIZE  = DEF_ARG_SIZE
)(
    input  logic           clk,
    input  logic           reset,
    data_mem_arbiter_if.slave bus
);

    arb_state_t           r_state;
    logic                 r_lastGnt;
    logic                 r_memRdEn, r_memWrEn;
    logic [ARG_SIZE-1:0]  r_memAddr;
    logic [DATA_SIZE-1:0] r_memWrData;
    logic                 r_tag1_vld, r_tag1_port;
    logic                 r_tag2_vld, r_tag2_port;

    logic w_gnt0, w_gnt1;

    // Ties in ARB go to the port that was not granted last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset) begin
            if (r_state == ST_ARB) begin
                w_gnt0 = bus.req0 & (~bus.req1 | r_lastGnt);
                w_gnt1 = bus.req1 & (~bus.req0 | ~r_lastGnt);
            end else if (r_state == ST_OWN0) begin
                w_gnt0 = bus.req0;
            end else if (r_state == ST_OWN1) begin
                w_gnt1 = bus.req1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ARB;
            r_lastGnt   <= 1'b1;
            r_memRdEn   <= 1'b0;
            r_memWrEn   <= 1'b0;
            r_memAddr   <= '0;
            r_memWrData <= '0;
            r_tag1_vld  <= 1'b0;
            r_tag1_port <= 1'b0;
            r_tag2_vld  <= 1'b0;
            r_tag2_port <= 1'b0;
        end else begin
            r_memRdEn <= 1'b0;
            r_memWrEn <= 1'b0;
            if (w_gnt0) begin
                r_memAddr   <= bus.addr0;
                r_memWrData <= bus.wrData0;
                r_memWrEn   <= bus.wr0;
                r_memRdEn   <= ~bus.wr0;
                r_lastGnt   <= 1'b0;
                r_state     <= bus.lock0 ? ST_OWN0 : ST_ARB;
            end else if (w_gnt1) begin
                r_memAddr   <= bus.addr1;
                r_memWrData <= bus.wrData1;
                r_memWrEn   <= bus.wr1;
                r_memRdEn   <= ~bus.wr1;
                r_lastGnt   <= 1'b1;
                r_state     <= bus.lock1 ? ST_OWN1 : ST_ARB;
            end else begin
                // No grant while owning means the owner dropped its request.
                r_state <= ST_ARB;
            end
            r_tag1_vld  <= (w_gnt0 & ~bus.wr0) | (w_gnt1 & ~bus.wr1);
            r_tag1_port <= w_gnt1;
            r_tag2_vld  <= r_tag1_vld;
            r_tag2_port <= r_tag1_port;
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.memRdEn   = r_memRdEn;
    assign bus.memWrEn   = r_memWrEn;
    assign bus.memAddr   = r_memAddr;
    assign bus.memWrData = r_memWrData;
    assign bus.rdValid0  = r_tag2_vld & ~r_tag2_port;
    assign bus.rdValid1  = r_tag2_vld &  r_tag2_port;
    assign bus.rdData    = reset ? bus.memRdData : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a synchronous memory model.
module tb_data_mem_arbiter;

    logic clk;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [7:0] mem [256];

    data_mem_arbiter_if #(.DATA_SIZE(8), .ARG_SIZE(8)) bus ();

    data_mem_arbiter #(.DATA_SIZE(8), .ARG_SIZE(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.memWrEn) mem[bus.memAddr] <= bus.memWrData;
        if (bus.memRdEn) bus.memRdData <= mem[bus.memAddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.lock0 = 1'b0;
        bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.lock1 = 1'b0;
    endtask

    initial begin
        for (int unsigned i = 0; i < 256; i++) mem[i] = 8'(255 - i);
        bus.memRdData = '0;
        idle();
        bus.addr0 = '0; bus.wrData0 = '0; bus.addr1 = '0; bus.wrData1 = '0;
        reset = 1'b0;

        // reset state, grants suppressed
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 8'h01; bus.addr1 = 8'h02;
        tick(); tick();
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_rden", bus.memRdEn, 0);
        chk("rst_wren", bus.memWrEn, 0);
        chk("rst_rdv0", bus.rdValid0, 0);
        chk("rst_rdv1", bus.rdValid1, 0);
        chk("rst_rdata", bus.rdData, 0);
        chk("rst_addr", bus.memAddr, 0);
        chk("rst_wdata", bus.memWrData, 0);

        // first tie after reset goes to port 0, then alternates
        reset = 1'b1;
        #1;
        chk("alt_gnt0_c0", bus.gnt0, 1);
        chk("alt_gnt1_c0", bus.gnt1, 0);
        tick(); #1;
        chk("alt_rden_c1", bus.memRdEn, 1);
        chk("alt_addr_c1", bus.memAddr, 8'h01);
        chk("alt_gnt0_c1", bus.gnt0, 0);
        chk("alt_gnt1_c1", bus.gnt1, 1);
        tick(); idle(); #1;
        chk("alt_addr_c2", bus.memAddr, 8'h02);
        chk("alt_rdv0_c2", bus.rdValid0, 1);
        chk("alt_rdv1_c2", bus.rdValid1, 0);
        chk("alt_rdata_c2", bus.rdData, 8'hFE);
        tick();
        chk("alt_rdv1_c3", bus.rdValid1, 1);
        chk("alt_rdv0_c3", bus.rdValid0, 0);
        chk("alt_rdata_c3", bus.rdData, 8'hFD);
        tick();

        // port 1 write A5 to 10, then read it back
        bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 8'h10; bus.wrData1 = 8'hA5;
        #1;
        chk("p1_gnt_wr", bus.gnt1, 1);
        tick();
        bus.wr1 = 1'b0;
        #1;
        chk("p1_wren", bus.memWrEn, 1);
        chk("p1_wdata", bus.memWrData, 8'hA5);
        chk("p1_waddr", bus.memAddr, 8'h10);
        chk("p1_gnt_rd", bus.gnt1, 1);
        tick(); idle(); #1;
        chk("p1_rden", bus.memRdEn, 1);
        chk("p1_wren_off", bus.memWrEn, 0);
        chk("p1_rdv1_early", bus.rdValid1, 0);
        tick();
        chk("p1_rdv1", bus.rdValid1, 1);
        chk("p1_rdv0", bus.rdValid0, 0);
        chk("p1_rdata", bus.rdData, 8'hA5);
        tick();
        chk("p1_rdv1_pulse", bus.rdValid1, 0);

        // lock: port 0 holds three grants while port 1 waits
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 8'h20; bus.wrData0 = 8'h11;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 8'h30;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.lock0 = 1'b0;
            #1;
            chk("lk_gnt0", bus.gnt0, 1);
            chk("lk_gnt1", bus.gnt1, 0);
            tick();
        end
        #1;
        chk("lk_rel_gnt1", bus.gnt1, 1);
        chk("lk_rel_gnt0", bus.gnt0, 0);
        tick(); idle(); #1;
        chk("lk_rden", bus.memRdEn, 1);
        tick();
        chk("lk_rdv1", bus.rdValid1, 1);
        chk("lk_rdata", bus.rdData, 8'hCF);
        tick();

        // owner drops request: other port waits one cycle in OWN0
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 8'h70;
        #1;
        chk("od_gnt0", bus.gnt0, 1);
        tick();
        idle();
        bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 8'h71;
        #1;
        chk("od_gnt1_own", bus.gnt1, 0);
        chk("od_gnt0_own", bus.gnt0, 0);
        tick(); #1;
        chk("od_gnt1_arb", bus.gnt1, 1);
        tick(); idle(); tick();

        // back-to-back alternating reads
        bus.req0 = 1'b1; bus.addr0 = 8'h40;
        bus.req1 = 1'b1; bus.addr1 = 8'h50;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) idle();
            #1;
            if (i < 4) begin
                chk("il_gnt0", bus.gnt0, 32'(i % 2 == 0));
                chk("il_gnt1", bus.gnt1, 32'(i % 2 == 1));
            end
            if (i >= 1 && i <= 4) chk("il_rden", bus.memRdEn, 1);
            if (i >= 2) begin
                chk("il_rdv0", bus.rdValid0, 32'(i % 2 == 0));
                chk("il_rdv1", bus.rdValid1, 32'(i % 2 == 1));
                chk("il_rdata", bus.rdData, (i % 2 == 0) ? 8'hBF : 8'hAF);
            end
            tick();
        end

        // reset the cycle after a read grant
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 8'h60;
        #1;
        chk("mr_gnt0", bus.gnt0, 1);
        tick(); idle(); #1;
        chk("mr_rden_pre", bus.memRdEn, 1);
        reset = 1'b0;
        #1;
        chk("mr_rden_rst", bus.memRdEn, 0);
        tick();
        chk("mr_rdv0_rst", bus.rdValid0, 0);
        chk("mr_rdata_rst", bus.rdData, 0);
        reset = 1'b1;
        tick();
        chk("mr_rdv0_a", bus.rdValid0, 0);
        tick();
        chk("mr_rdv0_b", bus.rdValid0, 0);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        #1;
        chk("mr_tie_gnt0", bus.gnt0, 1);
        chk("mr_tie_gnt1", bus.gnt1, 0);
        tick(); idle(); tick(); tick(); tick();

        // no requests for five cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("nr_gnt0", bus.gnt0, 0);
            chk("nr_gnt1", bus.gnt1, 0);
            chk("nr_rden", bus.memRdEn, 0);
            chk("nr_wren", bus.memWrEn, 0);
            chk("nr_rdv0", bus.rdValid0, 0);
            chk("nr_rdv1", bus.rdValid1, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
